seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
// PURPOSE
//   Parametrised multi-cycle adder/subtractor: WIDTH-bit operands are added CHUNK bits per clock,
//   with the carry held in a register between chunks. Trades latency for a short carry chain.
//   Sits between an operand source and a result consumer; valid/ready handshake on both sides.
//   Adds subtract mode, signed-overflow flag and a registered, held result.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK   4  bits added per clock; NCHUNK = WIDTH/CHUNK (CHUNK==WIDTH gives 1 chunk)
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      operands present
//   in_ready   out  1      block accepts operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   c_in       in   1      carry in (add mode only)
//   sub        in   1      0: a+b+c_in; 1: a-b (a + ~b + 1, c_in ignored)
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      consumer takes result
//   s          out  WIDTH  sum/difference
//   c_out      out  1      carry out of MSB (sub mode: 1 = no borrow)
//   ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async, any state, mid-operation included): state=IDLE, chunk index=0, carry reg=0,
//     s=0, c_out=0, ovf=0, out_valid=0, in_ready=1; any operation in flight is discarded.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE: in_ready=1. On in_valid: latch a, b^{WIDTH{sub}}, carry=(sub ? 1 : c_in), idx=0 -> RUN.
//     RUN: each cycle add chunk idx of latched operands + carry reg; write result into s[idx chunk],
//       carry reg <= chunk carry-out, idx++. When idx==NCHUNK-1 on that edge also set c_out, ovf -> DONE.
//     DONE: out_valid=1; s, c_out, ovf held stable. On out_ready -> IDLE (s/c_out/ovf keep value).
//   - Latency: accept edge to out_valid high = NCHUNK cycles (WIDTH16/CHUNK4: 4). Throughput
//     one op per NCHUNK+2 cycles with out_ready tied high.
//   - in_valid outside IDLE is ignored; no queueing. Operands may change freely after accept.
//   - out_ready outside DONE is ignored. in_ready and out_valid are decoded from state only
//     (no combinational path from in_valid/out_ready).
//   - s bits not yet computed in RUN are don't-care to the consumer; s is cleared to 0 on accept.
//   - Carry wraps naturally: all-ones + 1 ripples through every chunk via the carry register.
// STRUCTURE
//   - Shared package (adder_pkg): state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
//   - One sub-module: chunk_ripple_adder #(CHUNK) - combinational ripple of full-adder cells;
//     outputs sum[CHUNK], cout, and c_msb (carry into top bit) for ovf on the final chunk.
//   - Top: FSM, idx counter ($clog2(NCHUNK) bits, min 1), operand/carry/result registers, chunk mux.
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//   1. a=0x1234 b=0x4321 c_in=0 sub=0 -> s=0x5555 c_out=0 ovf=0; out_valid exactly 4 cycles after accept.
//   2. a=0xFFFF b=0x0001 c_in=0 -> s=0x0000 c_out=1 ovf=0 (carry crosses all 4 chunk boundaries);
//      a=0xFFFF b=0x0000 c_in=1 -> same result.
//   3. a=0x7FFF b=0x0001 sub=0 -> s=0x8000 c_out=0 ovf=1; sub=1 a=0x8000 b=0x0001 -> s=0x7FFF c_out=1 ovf=1.
//   4. sub=1 a=0x0005 b=0x0007 c_in=1 -> s=0xFFFE c_out=0 ovf=0 (c_in ignored).
//   5. out_ready=0 for 3 cycles in DONE -> out_valid, s, c_out, ovf stable; in_ready=0; in_valid pulses ignored.
//   6. reset pulsed in 2nd RUN cycle -> out_valid=0 s=0 in_ready=1 immediately; next op (test 1) correct.
//      Repeat test 1 with CHUNK=16 -> latency 1 cycle; with CHUNK=1 -> latency 16 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunked adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational ripple-carry adder over one CHUNK-bit slice.
module chunk_ripple_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);

    logic [CHUNK:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = c_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o  = c[CHUNK];
    // Carry into the top bit; XOR with cout gives signed overflow.
    assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract, CHUNK bits per clock with a registered carry.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    import adder_pkg::*;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_ch, b_ch, ch_sum;
    logic             ch_cout, ch_cmsb;
    logic             last;

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
        .a_i    (a_ch),
        .b_i    (b_ch),
        .c_i    (carry_q),
        .sum_o  (ch_sum),
        .cout_o (ch_cout),
        .c_msb_o(ch_cmsb)
    );

    assign last = (idx_q == IW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as a + ~b + 1: invert b here, seed carry with 1.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | c_in;
                    idx_d   = '0;
                    s_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = ch_cout;
                idx_d   = idx_q + IW'(1);
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IW'(k)) begin
                        s_d[k*CHUNK +: CHUNK] = ch_sum;
                    end
                end
                if (last) begin
                    c_out_d = ch_cout;
                    ovf_d   = ch_cout ^ ch_cmsb;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder against an arithmetic reference model.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        rr;
    logic        or_fixed;
    logic [15:0] a, b;
    logic        c_in, sub;
    logic        in_ready, out_valid, c_out, ovf;
    logic [15:0] s;

    logic        v16, v1, one;
    logic        r16, ov16, co16, of16;
    logic        r1, ov1, co1, of1;
    logic [15:0] s16, s1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) out_ready <= rr ? ($urandom_range(0, 3) != 0) : or_fixed;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_d16 (
        .clk(clk), .reset(reset), .in_valid(v16), .in_ready(r16),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(ov16),
        .out_ready(one), .s(s16), .c_out(co16), .ovf(of16)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(ov1),
        .out_ready(one), .s(s1), .c_out(co1), .ovf(of1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb,
                                   input int acc, input int lat);
        exp_t r;
        int ux, uy, sx, sy, u, sr;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 32768) ? ux - 65536 : ux;
        sy = (uy >= 32768) ? uy - 65536 : uy;
        if (sb) begin
            u    = ux - uy;
            sr   = sx - sy;
            r.co = (ux >= uy);
        end else begin
            u    = ux + uy + int'(ci);
            sr   = sx + sy + int'(ci);
            r.co = (u > 65535);
        end
        r.s   = 16'(u);
        r.ov  = (sr > 32767) || (sr < -32768);
        r.acc = acc;
        r.lat = lat;
        return r;
    endfunction

    logic pv = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            pv <= 1'b0;
        end else begin
            if (out_valid && !pv) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: actual=out_valid required=no result");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("s", 32'(s), 32'(e.s));
                    chk("c_out", 32'(c_out), 32'(e.co));
                    chk("ovf", 32'(ovf), 32'(e.ov));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            pv <= out_valid;
        end
    end

    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic sb);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: actual=0 required=1");
            return;
        end
        a        = x;
        b        = y;
        c_in     = ci;
        sub      = sb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(x, y, ci, sb, cyc, 4));
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        c_in     = 1'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", q.size());
            q.delete();
        end
    endtask

    task automatic lat_test(input int which);
        int acc, n, lat;
        logic got;
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; c_in = 1'b0; sub = 1'b0;
        if (which == 16) v16 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        v16 = 1'b0;
        v1  = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = (which == 16) ? ov16 : ov1;
        end
        lat = cyc - acc;
        if (which == 16) begin
            chk("lat_chunk16", 32'(lat), 32'd1);
            chk("s_chunk16", 32'(s16), 32'h5555);
        end else begin
            chk("lat_chunk1", 32'(lat), 32'd16);
            chk("s_chunk1", 32'(s1), 32'h5555);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        rr       = 1'b0;
        or_fixed = 1'b1;
        one      = 1'b1;
        v16      = 1'b0;
        v1       = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        #22;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        drain();

        // Result held while the consumer stalls.
        or_fixed = 1'b0;
        @(negedge clk);
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        chk("hold_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_s", 32'(s), 32'h2345);
            chk("hold_c_out", 32'(c_out), 32'd0);
            chk("hold_ovf", 32'(ovf), 32'd0);
        end
        in_valid = 1'b0;
        or_fixed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_s_kept", 32'(s), 32'h2345);
        drain();

        // Reset during the second RUN cycle discards the op.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        drain();

        rr = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 10 == 0) x = 16'hFFFF;
            if (i % 10 == 1) y = 16'h8000;
            issue(x, y, 1'($urandom), 1'($urandom));
        end
        drain();
        rr = 1'b0;
        @(negedge clk);
        @(negedge clk);

        lat_test(16);
        lat_test(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
